// File: rtl/health_tracker_pkg.sv
// Shared types and widths for the player health tracker.
package health_tracker_pkg;

  localparam int HEALTH_W = 4;
  localparam int TIMER_W  = 8;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  // Adds in one extra bit so the sum never wraps, then clamps to max_h.
  function automatic logic [HEALTH_W-1:0] sat_add(
    input logic [HEALTH_W-1:0] base,
    input logic [HEALTH_W-1:0] amt,
    input logic [HEALTH_W-1:0] max_h
  );
    logic [HEALTH_W:0] sum;
    sum = {1'b0, base} + {1'b0, amt};
    if (sum > {1'b0, max_h}) begin
      return max_h;
    end
    return sum[HEALTH_W-1:0];
  endfunction

endpackage

// File: rtl/health_tracker_frame_countdown.sv
// Loadable per-frame down-counter. expire pulses (combinationally) on the
// tick that takes the count from 1 to 0; load and clear take priority over
// a same-cycle tick, so a freshly loaded count is never shortened.
module frame_countdown
  import health_tracker_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             expire
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, then load, then decrement on tick (stops at zero).
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = tick && !clear && !load && (count_q == WIDTH'(1));

endmodule

// File: rtl/health_tracker.sv
// Player health state: damage/heal/respawn handling, post-hit invulnerability
// window counted in frames, sprite blink enable and HUD re-render pulse.
//
// state      | meaning
// ST_ALIVE   | normal play, damage and heal both apply
// ST_INVULN  | post-hit window, damage ignored, blink running
// ST_DEAD    | health is zero, only respawn has an effect
module health_tracker
  import health_tracker_pkg::*;
#(
  parameter int MAX_HEALTH    = 10,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                frame_tick,
  input  logic                damage,
  input  logic [HEALTH_W-1:0] damage_amt,
  input  logic                heal,
  input  logic [HEALTH_W-1:0] heal_amt,
  input  logic                respawn,
  output logic [HEALTH_W-1:0] health,
  output logic                dead,
  output logic                invuln,
  output logic                blink,
  output logic                health_changed
);

  localparam logic [HEALTH_W-1:0] MAX_H      = HEALTH_W'(MAX_HEALTH);
  localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(INVULN_FRAMES);
  localparam logic [3:0]          BLINK_TC   = 4'(BLINK_FRAMES);

  state_t              state_q, state_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic                blink_q, blink_d;
  logic [3:0]          blink_cnt_q, blink_cnt_d;
  logic                health_changed_q, health_changed_d;

  logic                timer_load;
  logic                timer_clear;
  logic                timer_expire;
  logic                dmg_valid;
  logic [HEALTH_W-1:0] health_less;
  logic [3:0]          blink_cnt_inc;

  frame_countdown #(.WIDTH(TIMER_W)) u_invuln_timer (
    .clk        (clk),
    .nrst       (nrst),
    .clear      (timer_clear),
    .load       (timer_load),
    .load_value (TIMER_LOAD),
    .tick       (frame_tick),
    .expire     (timer_expire)
  );

  // Event arbitration: respawn first, then per-state damage/heal/frame handling.
  always_comb begin
    state_d          = state_q;
    health_d         = health_q;
    blink_d          = blink_q;
    blink_cnt_d      = blink_cnt_q;
    timer_load       = 1'b0;
    timer_clear      = 1'b0;
    dmg_valid        = damage && (damage_amt != '0);
    health_less      = health_q - damage_amt;
    blink_cnt_inc    = blink_cnt_q + 4'd1;

    if (respawn) begin
      state_d     = ST_ALIVE;
      health_d    = MAX_H;
      blink_d     = 1'b0;
      blink_cnt_d = '0;
      timer_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_ALIVE: begin
          if (dmg_valid) begin
            if (damage_amt >= health_q) begin
              // Fatal hit discards any same-cycle heal.
              state_d  = ST_DEAD;
              health_d = '0;
            end else begin
              health_d    = heal ? sat_add(health_less, heal_amt, MAX_H) : health_less;
              state_d     = ST_INVULN;
              timer_load  = 1'b1;
              blink_d     = 1'b1;
              blink_cnt_d = '0;
            end
          end else if (heal) begin
            health_d = sat_add(health_q, heal_amt, MAX_H);
          end
        end
        ST_INVULN: begin
          if (heal) begin
            health_d = sat_add(health_q, heal_amt, MAX_H);
          end
          if (frame_tick) begin
            if (timer_expire) begin
              state_d     = ST_ALIVE;
              blink_d     = 1'b0;
              blink_cnt_d = '0;
            end else if (blink_cnt_inc == BLINK_TC) begin
              blink_d     = !blink_q;
              blink_cnt_d = '0;
            end else begin
              blink_cnt_d = blink_cnt_inc;
            end
          end
        end
        ST_DEAD: begin
        end
        default: begin
          state_d = ST_ALIVE;
        end
      endcase
    end

    health_changed_d = (health_d != health_q);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q          <= ST_ALIVE;
      health_q         <= MAX_H;
      blink_q          <= 1'b0;
      blink_cnt_q      <= '0;
      health_changed_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      health_q         <= health_d;
      blink_q          <= blink_d;
      blink_cnt_q      <= blink_cnt_d;
      health_changed_q <= health_changed_d;
    end
  end

  assign health         = health_q;
  assign dead           = (state_q == ST_DEAD);
  assign invuln         = (state_q == ST_INVULN);
  assign blink          = blink_q;
  assign health_changed = health_changed_q;

endmodule
